// File: rtl/satd_pkg.sv
// Shared widths and FSM encoding for the 4x4 SATD datapath.
// Widths are derived from the sample width so the core and its butterflies stay consistent.
package satd_pkg;

  localparam int DATA_W_DFLT = 8;

  function automatic int diff_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int hrow_w(input int dw);
    return dw + 3;
  endfunction

  function automatic int had_w(input int dw);
    return dw + 5;
  endfunction

  function automatic int satd_w(input int dw);
    return dw + 8;
  endfunction

  localparam int DIFF_W = diff_w(DATA_W_DFLT);
  localparam int HROW_W = hrow_w(DATA_W_DFLT);
  localparam int HAD_W  = had_w(DATA_W_DFLT);
  localparam int SATD_W = satd_w(DATA_W_DFLT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HROW = 2'd1,
    VCOL = 2'd2,
    DONE = 2'd3
  } satd_state_t;

endpackage

// File: rtl/satd_4x4_core_hadamard4.sv
// 4-point Hadamard butterfly, output two bits wider than input.
// Latency: combinational. Backpressure: none.
module hadamard4 #(
  parameter int IN_W = 9
) (
  input  logic signed [IN_W-1:0] x [4],
  output logic signed [IN_W+1:0] y [4]
);

  localparam int W1 = IN_W + 1;
  localparam int W2 = IN_W + 2;

  logic signed [W1-1:0] a, b, c, d;

  assign a = W1'(x[0]) + W1'(x[1]);
  assign b = W1'(x[0]) - W1'(x[1]);
  assign c = W1'(x[2]) + W1'(x[3]);
  assign d = W1'(x[2]) - W1'(x[3]);

  assign y[0] = W2'(a) + W2'(c);
  assign y[1] = W2'(b) + W2'(d);
  assign y[2] = W2'(a) - W2'(c);
  assign y[3] = W2'(b) - W2'(d);

endmodule

// File: rtl/satd_4x4_core.sv
// Captures a 4x4 residual block, runs a 2-D Hadamard and reports the scaled sum of |coeffs|.
// Latency: SATD_VALID in the 10th cycle after the index-15 capture edge.
// Backpressure: none; a block completing while BUSY is dropped and flagged on SEQ_ERR.
module satd_4x4_core
  import satd_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int SATD_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ENABLE_DIFF,
  input  logic              RESET_DIFF,
  input  logic [3:0]        COUNTER,
  input  logic [DATA_W-1:0] ORIG,
  input  logic [DATA_W-1:0] PRED,
  output logic [DATA_W+7:0] SATD_OUT,
  output logic              SATD_VALID,
  output logic              BUSY,
  output logic              SEQ_ERR
);

  localparam int DW = diff_w(DATA_W);
  localparam int HW = hrow_w(DATA_W);
  localparam int AW = had_w(DATA_W);
  localparam int SW = satd_w(DATA_W);

  logic signed [DW-1:0] cap [16];
  logic signed [HW-1:0] wrk [16];

  logic [3:0]  exp_idx;
  logic        blk_bad;
  logic        snap_req;
  satd_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [SW-1:0] acc_q;

  logic cap_en, out_of_seq, blk_end;
  logic signed [DW-1:0] diff;

  assign cap_en     = ENABLE_DIFF && !RESET_DIFF;
  assign out_of_seq = cap_en && (COUNTER != exp_idx);
  // A block only completes if every index arrived in order, including the last one.
  assign blk_end    = cap_en && (COUNTER == 4'd15) && !blk_bad && !out_of_seq;
  assign diff       = $signed({1'b0, ORIG}) - $signed({1'b0, PRED});
  assign BUSY       = (state_q != IDLE);

  logic signed [DW-1:0] row_in  [4];
  logic signed [HW-1:0] row_out [4];
  logic signed [HW-1:0] col_in  [4];
  logic signed [AW-1:0] col_out [4];
  logic        [AW-1:0] col_abs [4];
  logic        [SW-1:0] col_sum;

  for (genvar k = 0; k < 4; k++) begin : g_sel
    assign row_in[k]  = wrk[{idx_q, 2'(k)}][DW-1:0];
    assign col_in[k]  = wrk[{2'(k), idx_q}];
    assign col_abs[k] = col_out[k][AW-1] ? -col_out[k] : col_out[k];
  end

  assign col_sum = SW'(col_abs[0]) + SW'(col_abs[1]) + SW'(col_abs[2]) + SW'(col_abs[3]);

  hadamard4 #(.IN_W(DW)) u_row_had (.x(row_in), .y(row_out));
  hadamard4 #(.IN_W(HW)) u_col_had (.x(col_in), .y(col_out));

  always_ff @(posedge clk) begin
    if (cap_en) cap[COUNTER] <= diff;
  end

  // Row results overwrite their own row so the column pass reads the same array.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && snap_req) begin
      for (int i = 0; i < 16; i++) wrk[i] <= HW'(cap[i]);
    end else if (state_q == HROW) begin
      for (int c = 0; c < 4; c++) wrk[{idx_q, 2'(c)}] <= row_out[c];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d = HROW;
          idx_d   = 2'd0;
        end
      end
      HROW: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = VCOL;
      end
      VCOL: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      acc_q      <= '0;
      exp_idx    <= 4'd0;
      blk_bad    <= 1'b0;
      snap_req   <= 1'b0;
      SATD_OUT   <= '0;
      SATD_VALID <= 1'b0;
      SEQ_ERR    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_req   <= blk_end;
      SEQ_ERR    <= out_of_seq || (snap_req && state_q != IDLE);
      SATD_VALID <= 1'b0;

      // Result lands on the edge into DONE so SATD_VALID is high while the FSM sits there.
      if (state_q == VCOL) begin
        if (idx_q == 2'd3) begin
          SATD_OUT   <= (acc_q + col_sum) >> SATD_SHIFT;
          SATD_VALID <= 1'b1;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_q + col_sum;
        end
      end

      if (RESET_DIFF) begin
        exp_idx <= 4'd0;
        blk_bad <= 1'b0;
      end else if (ENABLE_DIFF) begin
        exp_idx <= COUNTER + 4'd1;
        if (COUNTER == 4'd0)  blk_bad <= 1'b0;
        else if (out_of_seq)  blk_bad <= 1'b1;
      end
    end
  end

endmodule
